// File: rtl/div_req_scheduler.sv
// Shares one fixed-latency divider among NREQ requesters: round-robin issue, a tag
// pipe that tracks ops through the divider, and a credit-guarded result FIFO.
module div_req_scheduler #(
  parameter int NREQ       = 4,
  parameter int TE_BITS    = 8,
  parameter int MANT_SIZE  = 14,
  parameter int MANT_RES   = 39,
  parameter int DIV_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // Handshakes: a request transfers on req_valid_i[i] & req_ready_o[i]; ready is a
  // grant, never raised without valid. A result transfers on rsp_valid_o & rsp_ready_i;
  // rsp_valid_o and the rsp_* payload hold until accepted.
  input  logic [NREQ-1:0]               req_valid_i,
  output logic [NREQ-1:0]               req_ready_o,
  input  logic [NREQ*TE_BITS-1:0]       req_te1_i,
  input  logic [NREQ*TE_BITS-1:0]       req_te2_i,
  input  logic [NREQ*MANT_SIZE-1:0]     req_mant1_i,
  input  logic [NREQ*MANT_SIZE-1:0]     req_mant2_i,
  output logic [TE_BITS-1:0]            div_te1_o,
  output logic [TE_BITS-1:0]            div_te2_o,
  output logic [MANT_SIZE-1:0]          div_mant1_o,
  output logic [MANT_SIZE-1:0]          div_mant2_o,
  input  logic [MANT_RES-1:0]           div_mant_i,
  input  logic [TE_BITS-1:0]            div_te_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [$clog2(NREQ)-1:0]       rsp_id_o,
  output logic [MANT_RES-1:0]           rsp_mant_o,
  output logic [TE_BITS-1:0]            rsp_te_o,
  output logic                          busy_o
);
  localparam int ID_W  = $clog2(NREQ);
  localparam int ENT_W = ID_W + MANT_RES + TE_BITS;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + DIV_LAT + 1);

  logic [ID_W-1:0]  ptr_q, ptr_d, grant_id, push_id;
  logic             grant_found, can_issue, issue, push, pop;
  logic [CNT_W-1:0] inflight, credit_used, cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0] mem_d [FIFO_DEPTH];
  logic [ENT_W-1:0] head;

  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid_i[idx]) begin
        grant_found = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Every op counted here already owns a FIFO slot, so arrivals can never overflow.
  assign credit_used = inflight + cnt_q;
  assign can_issue   = credit_used < CNT_W'(FIFO_DEPTH);
  assign issue       = grant_found & can_issue & ~rst;

  always_comb begin
    req_ready_o = '0;
    div_te1_o   = '0;
    div_te2_o   = '0;
    div_mant1_o = '0;
    div_mant2_o = '0;
    ptr_d       = ptr_q;
    if (issue) begin
      req_ready_o[grant_id] = 1'b1;
      div_te1_o   = req_te1_i[int'(grant_id)*TE_BITS +: TE_BITS];
      div_te2_o   = req_te2_i[int'(grant_id)*TE_BITS +: TE_BITS];
      div_mant1_o = req_mant1_i[int'(grant_id)*MANT_SIZE +: MANT_SIZE];
      div_mant2_o = req_mant2_i[int'(grant_id)*MANT_SIZE +: MANT_SIZE];
      ptr_d       = (grant_id == ID_W'(NREQ-1)) ? '0 : grant_id + 1'b1;
    end
  end

  generate
    if (DIV_LAT == 0) begin : g_nopipe
      assign push     = issue;
      assign push_id  = grant_id;
      assign inflight = '0;
    end else begin : g_pipe
      logic [DIV_LAT-1:0] tag_v_q, tag_v_d;
      logic [ID_W-1:0]    tag_id_q [DIV_LAT];
      logic [ID_W-1:0]    tag_id_d [DIV_LAT];

      always_comb begin
        tag_v_d[0]  = issue;
        tag_id_d[0] = grant_id;
        for (int s = 1; s < DIV_LAT; s++) begin
          tag_v_d[s]  = tag_v_q[s-1];
          tag_id_d[s] = tag_id_q[s-1];
        end
        inflight = '0;
        for (int s = 0; s < DIV_LAT; s++) inflight = inflight + CNT_W'(tag_v_q[s]);
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          tag_v_q  <= '0;
          tag_id_q <= '{default: '0};
        end else begin
          tag_v_q  <= tag_v_d;
          tag_id_q <= tag_id_d;
        end
      end

      assign push    = tag_v_q[DIV_LAT-1];
      assign push_id = tag_id_q[DIV_LAT-1];
    end
  endgenerate

  assign pop = rsp_valid_o & rsp_ready_i;

  // On a push+pop at full, wr_ptr equals rd_ptr: the head is read this cycle and
  // overwritten at the edge, which is exactly the required behaviour.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = {push_id, div_mant_i, div_te_i};
      wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= '0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      ptr_q    <= ptr_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign rsp_valid_o = (cnt_q != '0) & ~rst;
  assign rsp_id_o    = rsp_valid_o ? head[ENT_W-1 -: ID_W] : '0;
  assign rsp_mant_o  = rsp_valid_o ? head[TE_BITS +: MANT_RES] : '0;
  assign rsp_te_o    = rsp_valid_o ? head[TE_BITS-1:0] : '0;
  assign busy_o      = (inflight != '0) | (cnt_q != '0);

  no_push_on_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && cnt_q == CNT_W'(FIFO_DEPTH)));

endmodule

// File: tb/tb_div_req_scheduler.sv
// Directed bench for div_req_scheduler: a DIV_LAT=1 instance plus a DIV_LAT=0 instance,
// each fed by a stand-in divider whose result is a known function of the operands.
module tb_div_req_scheduler;
  localparam int NREQ = 4, TE_BITS = 8, MANT_SIZE = 14, MANT_RES = 39, ID_W = 2;

  // clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ*TE_BITS-1:0]   req_te1, req_te2;
  logic [NREQ*MANT_SIZE-1:0] req_mant1, req_mant2;

  logic [NREQ-1:0]      req_valid, req_ready;
  logic [TE_BITS-1:0]   div_te1, div_te2, div_te_in, rsp_te;
  logic [MANT_SIZE-1:0] div_mant1, div_mant2;
  logic [MANT_RES-1:0]  div_mant_in, rsp_mant;
  logic                 rsp_valid, rsp_ready, busy;
  logic [ID_W-1:0]      rsp_id;

  logic [NREQ-1:0]      req_valid_z, req_ready_z;
  logic [TE_BITS-1:0]   div_te1_z, div_te2_z, div_te_in_z, rsp_te_z;
  logic [MANT_SIZE-1:0] div_mant1_z, div_mant2_z;
  logic [MANT_RES-1:0]  div_mant_in_z, rsp_mant_z;
  logic                 rsp_valid_z, rsp_ready_z, busy_z;
  logic [ID_W-1:0]      rsp_id_z;

  div_req_scheduler #(.NREQ(NREQ), .TE_BITS(TE_BITS), .MANT_SIZE(MANT_SIZE),
                      .MANT_RES(MANT_RES), .DIV_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_te1_i(req_te1), .req_te2_i(req_te2), .req_mant1_i(req_mant1), .req_mant2_i(req_mant2),
    .div_te1_o(div_te1), .div_te2_o(div_te2), .div_mant1_o(div_mant1), .div_mant2_o(div_mant2),
    .div_mant_i(div_mant_in), .div_te_i(div_te_in),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_mant_o(rsp_mant), .rsp_te_o(rsp_te), .busy_o(busy)
  );

  div_req_scheduler #(.NREQ(NREQ), .TE_BITS(TE_BITS), .MANT_SIZE(MANT_SIZE),
                      .MANT_RES(MANT_RES), .DIV_LAT(0), .FIFO_DEPTH(4)) dut_z (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_z), .req_ready_o(req_ready_z),
    .req_te1_i(req_te1), .req_te2_i(req_te2), .req_mant1_i(req_mant1), .req_mant2_i(req_mant2),
    .div_te1_o(div_te1_z), .div_te2_o(div_te2_z), .div_mant1_o(div_mant1_z), .div_mant2_o(div_mant2_z),
    .div_mant_i(div_mant_in_z), .div_te_i(div_te_in_z),
    .rsp_valid_o(rsp_valid_z), .rsp_ready_i(rsp_ready_z), .rsp_id_o(rsp_id_z),
    .rsp_mant_o(rsp_mant_z), .rsp_te_o(rsp_te_z), .busy_o(busy_z)
  );

  // Stand-in divider: mantissa result is {pad, mant1, mant2}, exponent is te1 - te2.
  function automatic logic [MANT_RES-1:0] stub_mant(input logic [MANT_SIZE-1:0] m1,
                                                    input logic [MANT_SIZE-1:0] m2);
    return {{(MANT_RES-2*MANT_SIZE){1'b0}}, m1, m2};
  endfunction

  always_ff @(posedge clk) begin
    div_mant_in <= stub_mant(div_mant1, div_mant2);
    div_te_in   <= div_te1 - div_te2;
  end
  assign div_mant_in_z = stub_mant(div_mant1_z, div_mant2_z);
  assign div_te_in_z   = div_te1_z - div_te2_z;

  logic [TE_BITS-1:0]   lane_te1 [NREQ] = '{8'h31, 8'h42, 8'h53, 8'h64};
  logic [TE_BITS-1:0]   lane_te2 [NREQ] = '{8'h01, 8'h02, 8'h03, 8'h04};
  logic [TE_BITS-1:0]   exp_te   [NREQ] = '{8'h30, 8'h40, 8'h50, 8'h60};
  logic [MANT_SIZE-1:0] lane_m1  [NREQ] = '{14'h0123, 14'h0456, 14'h3000, 14'h0789};
  logic [MANT_SIZE-1:0] lane_m2  [NREQ] = '{14'h0011, 14'h0022, 14'h2000, 14'h0033};

  function automatic logic [MANT_RES-1:0] exp_mant(input int id);
    return stub_mant(lane_m1[id], lane_m2[id]);
  endfunction

  // scoreboard
  int              tests_run = 0;
  int              tests_failed = 0;
  string           step = "init";
  logic [ID_W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", step, tag, obs, exp);
    end
  endtask

  task automatic check_rsp();
    logic [ID_W-1:0] id;
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_extra", 64'(rsp_valid), 64'd0);
      else begin
        id = exp_q.pop_front();
        chk("rsp_id", rsp_id, id);
        chk("rsp_mant", rsp_mant, exp_mant(int'(id)));
        chk("rsp_te", rsp_te, exp_te[id]);
      end
    end
  endtask

  // driver tasks: inputs change 1 time unit after posedge, outputs sampled at negedge
  task automatic at_neg(input logic [NREQ-1:0] exp_ready, input logic exp_rv);
    @(negedge clk);
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, exp_rv);
    for (int i = 0; i < NREQ; i++) if (exp_ready[i]) exp_q.push_back(ID_W'(i));
    check_rsp();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      req_te1[i*TE_BITS +: TE_BITS]       = lane_te1[i];
      req_te2[i*TE_BITS +: TE_BITS]       = lane_te2[i];
      req_mant1[i*MANT_SIZE +: MANT_SIZE] = lane_m1[i];
      req_mant2[i*MANT_SIZE +: MANT_SIZE] = lane_m2[i];
    end
    rst = 1'b1; req_valid = 4'hF; rsp_ready = 1'b0; req_valid_z = '0; rsp_ready_z = 1'b0;

    step = "reset";
    repeat (2) @(posedge clk);
    at_neg(4'b0000, 1'b0);
    chk("busy", busy, 1'b0);
    chk("div_te1", div_te1, 8'h00);
    chk("div_mant1", div_mant1, 14'h0);
    chk("rsp_id", rsp_id, 2'd0);
    chk("rsp_mant", rsp_mant, 39'd0);
    chk("rsp_te", rsp_te, 8'h00);
    chk("busy_z", busy_z, 1'b0);
    adv();
    rst = 1'b0; req_valid = 4'b0100; rsp_ready = 1'b1;

    step = "single";
    at_neg(4'b0100, 1'b0);
    chk("div_mant1", div_mant1, 14'h3000);
    chk("div_mant2", div_mant2, 14'h2000);
    chk("div_te1", div_te1, 8'h53);
    chk("div_te2", div_te2, 8'h03);
    adv(); req_valid = '0;
    at_neg(4'b0000, 1'b0);
    chk("busy", busy, 1'b1);
    adv();
    at_neg(4'b0000, 1'b1);
    adv();
    at_neg(4'b0000, 1'b0);
    chk("busy", busy, 1'b0);
    adv(); rst = 1'b1; req_valid = 4'hF;

    step = "stream";
    at_neg(4'b0000, 1'b0);
    adv(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      at_neg(4'(1 << (k % 4)), k >= 2);
      adv();
    end
    req_valid = '0;
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0000, 1'b0);
    chk("busy", busy, 1'b0);
    adv(); req_valid = 4'hF; rsp_ready = 1'b0;

    step = "backpressure";
    at_neg(4'b0001, 1'b0); adv();
    at_neg(4'b0010, 1'b0); adv();
    at_neg(4'b0100, 1'b1); adv();
    at_neg(4'b1000, 1'b1); adv();
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0000, 1'b1);
    chk("busy", busy, 1'b1);
    adv(); rsp_ready = 1'b1;
    at_neg(4'b0000, 1'b1);
    adv(); rsp_ready = 1'b0;
    at_neg(4'b0001, 1'b1); adv();
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0000, 1'b1);
    adv(); rsp_ready = 1'b1;

    step = "full_push_pop";
    at_neg(4'b0000, 1'b1); adv();
    at_neg(4'b0010, 1'b1); adv();
    at_neg(4'b0100, 1'b1); adv();
    at_neg(4'b1000, 1'b1);
    adv(); req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      at_neg(4'b0000, 1'b1);
      adv();
    end
    at_neg(4'b0000, 1'b0);
    chk("busy", busy, 1'b0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    adv(); req_valid = 4'b0111; rsp_ready = 1'b0;

    step = "reset_midop";
    at_neg(4'b0001, 1'b0); adv();
    at_neg(4'b0010, 1'b0); adv();
    at_neg(4'b0100, 1'b1); adv();
    at_neg(4'b0001, 1'b1);
    adv(); rst = 1'b1;
    at_neg(4'b0000, 1'b0);
    exp_q.delete();
    adv(); rst = 1'b0; rsp_ready = 1'b1;
    at_neg(4'b0001, 1'b0);
    chk("busy", busy, 1'b0);
    adv(); req_valid = '0;
    at_neg(4'b0000, 1'b0); adv();
    at_neg(4'b0000, 1'b1); adv();
    for (int k = 0; k < 4; k++) begin
      at_neg(4'b0000, 1'b0);
      adv();
    end
    chk("busy", busy, 1'b0);
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    req_valid_z = 4'b0010; rsp_ready_z = 1'b1;

    step = "lat0";
    @(negedge clk);
    chk("req_ready_z", req_ready_z, 4'b0010);
    chk("rsp_valid_z", rsp_valid_z, 1'b0);
    chk("div_mant1_z", div_mant1_z, 14'h0456);
    adv(); req_valid_z = '0;
    @(negedge clk);
    chk("rsp_valid_z", rsp_valid_z, 1'b1);
    chk("rsp_id_z", rsp_id_z, 2'd1);
    chk("rsp_mant_z", rsp_mant_z, exp_mant(1));
    chk("rsp_te_z", rsp_te_z, 8'h40);
    adv();
    @(negedge clk);
    chk("rsp_valid_z", rsp_valid_z, 1'b0);
    chk("busy_z", busy_z, 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
